// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory hierarchy.
//   lc3b_word        16-bit byte address / data word
//   lc3b_l2_line     128-bit cache line moved between L2 and physical memory
//   lc3b_pmem_cnt    latency counter of the physical-memory responder
//   lc3b_pmem_state  responder FSM states
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_l2_line;
  typedef logic [7:0]   lc3b_pmem_cnt;

  typedef enum logic [1:0] {
    PMEM_IDLE,
    PMEM_BUSY,
    PMEM_RESP,
    PMEM_DONE
  } lc3b_pmem_state;

  // Byte-offset bits inside a 16-byte line; they never reach the line index.
  localparam int unsigned PmemOffsetBits = 4;

  // Largest latency the 8-bit counter can express.
  localparam int unsigned PmemMaxLatency = 255;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage for the physical-memory responder.
// 2^LINE_ADDR_BITS lines of 128 bits, one synchronous write port and one
// synchronous read port, no reset (contents survive a responder reset).
// Ports:
//   clk    clock
//   we     write enable, wdata stored at waddr on the rising edge
//   waddr  write line index
//   wdata  write line
//   re     read enable, rdata loaded from raddr on the rising edge
//   raddr  read line index
//   rdata  registered read line (old data on same-edge read/write collision)
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int unsigned LINE_ADDR_BITS = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [LINE_ADDR_BITS-1:0] waddr,
  input  lc3b_l2_line               wdata,
  input  logic                      re,
  input  logic [LINE_ADDR_BITS-1:0] raddr,
  output lc3b_l2_line               rdata
);

  localparam int unsigned Lines = 2 ** LINE_ADDR_BITS;

  lc3b_l2_line mem [Lines];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder for the cache line interface.
// Accepts a line read or write, waits LATENCY cycles, then pulses pmem_resp
// for one cycle, followed by one turnaround cycle in which requests are
// ignored. Request timeline: seen in cycle 0, resp in cycle LATENCY+1,
// next acceptance possible in cycle LATENCY+3.
// Ports:
//   clk           clock, rising edge
//   reset_n       synchronous active-low reset
//   pmem_read     line read request, held until pmem_resp
//   pmem_write    line write request, held until pmem_resp (wins over read)
//   pmem_address  byte address; bits [3:0] ignored, bits above the index alias
//   pmem_wdata    write line
//   pmem_rdata    registered read line, held until the next read completes
//   pmem_resp     registered one-cycle completion pulse
//   pmem_error    sticky protocol-violation flag, cleared only by reset
module pmem_responder
  import lc3b_types::*;
#(
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned LINE_ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  lc3b_word    pmem_address,
  input  lc3b_l2_line pmem_wdata,
  output lc3b_l2_line pmem_rdata,
  output logic        pmem_resp,
  output logic        pmem_error
);

  localparam int unsigned IdxHi = LINE_ADDR_BITS + PmemOffsetBits - 1;

  if (LATENCY == 0 || LATENCY > PmemMaxLatency) begin : g_bad_latency
    $error("pmem_responder: LATENCY must be in 1..255");
  end
  if (LINE_ADDR_BITS == 0 || LINE_ADDR_BITS > 12) begin : g_bad_addr_bits
    $error("pmem_responder: LINE_ADDR_BITS must be in 1..12");
  end

  lc3b_pmem_state state_q, state_d;
  lc3b_pmem_cnt   cnt_q, cnt_d;
  logic           resp_q, resp_d;
  logic           error_q, error_d;
  lc3b_l2_line    rdata_q, rdata_d;

  // Request captured at acceptance. The raw read/write bits and the full
  // address are kept so that any change while busy can be flagged.
  logic           op_write_q;
  logic           req_read_q;
  logic           req_write_q;
  lc3b_word       addr_q;
  lc3b_l2_line    wdata_q;

  logic           accept;
  logic           req_live;

  logic [LINE_ADDR_BITS-1:0] addr_idx;
  logic [LINE_ADDR_BITS-1:0] latched_idx;
  logic [LINE_ADDR_BITS-1:0] arr_raddr;
  logic                      arr_re;
  logic                      arr_we;
  lc3b_l2_line               arr_rdata;

  assign addr_idx    = pmem_address[IdxHi:PmemOffsetBits];
  assign latched_idx = addr_q[IdxHi:PmemOffsetBits];

  // The accepted op's own request line; its drop during BUSY aborts.
  assign req_live = op_write_q ? pmem_write : pmem_read;

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    accept  = 1'b0;

    unique case (state_q)
      PMEM_IDLE: begin
        if (pmem_read || pmem_write) begin
          accept  = 1'b1;
          cnt_d   = lc3b_pmem_cnt'(LATENCY - 1);
          state_d = PMEM_BUSY;
          if (pmem_read && pmem_write) begin
            error_d = 1'b1;
          end
        end
      end
      PMEM_BUSY: begin
        if (!req_live) begin
          state_d = PMEM_IDLE;
        end else begin
          if ((pmem_read != req_read_q) || (pmem_write != req_write_q) ||
              (pmem_address != addr_q)) begin
            error_d = 1'b1;
          end
          if (cnt_q != '0) begin
            cnt_d = cnt_q - lc3b_pmem_cnt'(1);
          end else begin
            state_d = PMEM_RESP;
          end
        end
      end
      PMEM_RESP: state_d = PMEM_DONE;
      PMEM_DONE: state_d = PMEM_IDLE;
      default:   state_d = PMEM_IDLE;
    endcase

    resp_d = (state_d == PMEM_RESP);

    // Read data is captured on the edge that enters RESP.
    rdata_d = rdata_q;
    if ((state_q == PMEM_BUSY) && (state_d == PMEM_RESP) && !op_write_q) begin
      rdata_d = arr_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= PMEM_IDLE;
      cnt_q       <= '0;
      resp_q      <= 1'b0;
      error_q     <= 1'b0;
      rdata_q     <= '0;
      op_write_q  <= 1'b0;
      req_read_q  <= 1'b0;
      req_write_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
      if (accept) begin
        op_write_q  <= pmem_write;
        req_read_q  <= pmem_read;
        req_write_q <= pmem_write;
        addr_q      <= pmem_address;
      end
    end
  end

  // Write data needs no reset; it is only consumed after a fresh accept.
  always_ff @(posedge clk) begin
    if (reset_n && accept && pmem_write) begin
      wdata_q <= pmem_wdata;
    end
  end

  // The array is read continuously while idle (from the live address) and
  // busy (from the latched address), so the line for the accepted index is
  // already registered by the time the counter reaches zero, for any LATENCY.
  assign arr_re    = (state_q == PMEM_IDLE) || (state_q == PMEM_BUSY);
  assign arr_raddr = (state_q == PMEM_IDLE) ? addr_idx : latched_idx;

  // Writes commit on the edge leaving RESP; a reset on that edge drops them.
  assign arr_we = (state_q == PMEM_RESP) && op_write_q && reset_n;

  pmem_line_array #(
    .LINE_ADDR_BITS(LINE_ADDR_BITS)
  ) u_line_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (latched_idx),
    .wdata (wdata_q),
    .re    (arr_re),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  assign pmem_resp  = resp_q;
  assign pmem_error = error_q;
  assign pmem_rdata = rdata_q;

endmodule

// File: tb/tb_pmem_responder.sv
module tb_pmem_responder;

  localparam int L = 4;

  logic         clk;
  logic         reset_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_error;

  pmem_responder #(
    .LATENCY(L),
    .LINE_ADDR_BITS(8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .pmem_error   (pmem_error)
  );

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Transaction-level model: each accepted request owns a window of cycles
  // [acc, acc+L+2]; resp lands in cycle acc+L+1. Dropping the request in
  // cycles acc+1..acc+L cancels it.
  // ---------------------------------------------------------------------
  int           cyc = 0;
  bit           model_valid = 0;
  bit           busy = 0;
  int           acc;
  bit           m_wr, m_rd_raw, m_wr_raw;
  logic [15:0]  m_addr;
  logic [127:0] m_data;
  logic [127:0] mem_model [256];
  logic         exp_resp = 0;
  logic         exp_err = 0;
  logic [127:0] exp_rdata = '0;

  task automatic model_step();
    if (!reset_n) begin
      busy = 0;
      exp_resp = 0;
      exp_err = 0;
      exp_rdata = '0;
      model_valid = 1;
    end else begin
      exp_resp = 0;
      if (busy) begin
        if (cyc <= acc + L) begin
          if (m_wr ? !pmem_write : !pmem_read) begin
            busy = 0;
          end else begin
            if (pmem_read != m_rd_raw || pmem_write != m_wr_raw || pmem_address != m_addr)
              exp_err = 1;
            if (cyc == acc + L) begin
              exp_resp = 1;
              if (m_wr) mem_model[m_addr[11:4]] = m_data;
              else exp_rdata = mem_model[m_addr[11:4]];
            end
          end
        end else if (cyc == acc + L + 2) begin
          busy = 0;
        end
      end else if (pmem_read || pmem_write) begin
        busy = 1;
        acc = cyc;
        m_wr = pmem_write;
        m_rd_raw = pmem_read;
        m_wr_raw = pmem_write;
        m_addr = pmem_address;
        m_data = pmem_wdata;
        if (pmem_read && pmem_write) exp_err = 1;
      end
    end
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      chk("cyc_resp", pmem_resp, exp_resp);
      chk("cyc_error", pmem_error, exp_err);
      chk("cyc_rdata", pmem_rdata, exp_rdata);
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  localparam logic [127:0] LineX = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] LineD = 128'hDEADBEEF_0123_4567_89AB_CDEF_0011_2233;
  localparam logic [127:0] LineA = 128'hAAAA5555_AAAA5555_AAAA5555_AAAA5555;
  localparam logic [127:0] LineP = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] LineB = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;
  localparam logic [127:0] LineC = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;

  // One request with an on-time drop; returns resp latency in cycles
  // (cycle of first-high = 0), or -1 on timeout. Leaves the DUT in IDLE.
  task automatic req(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [127:0] data, output int lat);
    int t0;
    @(negedge clk);
    pmem_read = rd;
    pmem_write = wr;
    pmem_address = addr;
    pmem_wdata = data;
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pmem_resp) begin
        lat = cyc - t0;
        break;
      end
    end
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int t0;
    int n;
    int rc[3];
    logic [15:0] b2b_addr[3];
    logic [127:0] b2b_data[3];

    reset_n = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    chk("reset_resp", pmem_resp, 1'b0);
    chk("reset_rdata", pmem_rdata, 128'h0);
    chk("reset_error", pmem_error, 1'b0);

    // Seed a line, then reset with a read pending; array survives reset.
    req(1'b0, 1'b1, 16'h0050, LineX, lat);
    chk("seed_wr_lat", lat, 5);
    @(negedge clk);
    reset_n = 1'b0;
    pmem_read = 1'b1;
    pmem_address = 16'h0050;
    repeat (3) @(negedge clk);
    chk("rst_hold_resp", pmem_resp, 1'b0);
    chk("rst_hold_rdata", pmem_rdata, 128'h0);
    reset_n = 1'b1;
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pmem_resp) begin
        lat = cyc - t0;
        break;
      end
    end
    chk("rst_rd_lat", lat, 5);
    chk("rst_rd_data", pmem_rdata, LineX);
    pmem_read = 1'b0;
    @(negedge clk);

    // Write then read, same line, different byte offset.
    req(1'b0, 1'b1, 16'h0120, LineD, lat);
    chk("wr_lat", lat, 5);
    req(1'b1, 1'b0, 16'h012E, '0, lat);
    chk("rd_lat", lat, 5);
    chk("rd_data", pmem_rdata, LineD);

    // Aliasing: bits above the 8-bit index are ignored.
    req(1'b0, 1'b1, 16'h0010, LineA, lat);
    req(1'b1, 1'b0, 16'h1010, '0, lat);
    chk("alias_data", pmem_rdata, LineA);

    // Abort: write B dropped in cycle 2 must leave prior line P intact.
    req(1'b0, 1'b1, 16'h0200, LineP, lat);
    @(negedge clk);
    pmem_write = 1'b1;
    pmem_address = 16'h0200;
    pmem_wdata = LineB;
    repeat (2) @(negedge clk);
    pmem_write = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pmem_resp) n++;
    end
    chk("abort_resps", n, 0);
    req(1'b1, 1'b0, 16'h0200, '0, lat);
    chk("abort_rd_lat", lat, 5);
    chk("abort_rd_data", pmem_rdata, LineP);

    // Back-to-back reads, read held continuously, final drop one cycle late.
    b2b_addr[0] = 16'h0120; b2b_data[0] = LineD;
    b2b_addr[1] = 16'h0010; b2b_data[1] = LineA;
    b2b_addr[2] = 16'h0200; b2b_data[2] = LineP;
    @(negedge clk);
    pmem_read = 1'b1;
    pmem_address = b2b_addr[0];
    t0 = cyc;
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (pmem_resp) begin
        rc[n] = cyc;
        chk("b2b_data", pmem_rdata, b2b_data[n]);
        n++;
        @(negedge clk);
        if (n < 3) pmem_address = b2b_addr[n];
      end
    end
    @(negedge clk);
    pmem_read = 1'b0;
    chk("b2b_count", n, 3);
    if (n == 3) begin
      chk("b2b_first_lat", rc[0] - t0, 5);
      chk("b2b_gap0", rc[1] - rc[0], 7);
      chk("b2b_gap1", rc[2] - rc[1], 7);
    end
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pmem_resp) n++;
    end
    chk("b2b_no_extra", n, 0);
    chk("b2b_no_error", pmem_error, 1'b0);

    // Conflict: write wins, error goes sticky.
    req(1'b1, 1'b1, 16'h0300, LineC, lat);
    chk("conf_lat", lat, 5);
    chk("conf_error", pmem_error, 1'b1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pmem_resp) n++;
    end
    chk("conf_single_resp", n, 0);
    req(1'b1, 1'b0, 16'h0300, '0, lat);
    chk("conf_rd_data", pmem_rdata, LineC);
    chk("conf_error_sticky", pmem_error, 1'b1);

    // Reset clears the sticky error and rdata.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("final_rst_error", pmem_error, 1'b0);
    chk("final_rst_rdata", pmem_rdata, 128'h0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Memory-side responder for the cache line interface. It answers line read and line write requests issued by the L2 cache (or by L1 directly in L2-less builds). Each request is served after a programmable latency from an internal line array, with a single-cycle `pmem_resp` completion pulse. It sits below the cache hierarchy as the physical-memory model for simulation and FPGA builds.

## Interface
Parameters:
- `LATENCY`, default 4: cycles from request acceptance to `pmem_resp`. Legal range is 1..255.
- `LINE_ADDR_BITS`, default 8: number of line-index bits. The array holds 2^LINE_ADDR_BITS lines of 128 bits.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `pmem_read`, in, 1: line read request. Held high until `pmem_resp`.
- `pmem_write`, in, 1: line write request. Held high until `pmem_resp`.
- `pmem_address`, in, 16 (`lc3b_word`): byte address. Bits [3:0] are ignored.
- `pmem_wdata`, in, 128 (`lc3b_l2_line`): write line. Must be stable while `pmem_write` is high.
- `pmem_rdata`, out, 128 (`lc3b_l2_line`): read line. Valid while `pmem_resp` is high, then held until the next read completes.
- `pmem_resp`, out, 1: one-cycle completion pulse.
- `pmem_error`, out, 1: sticky flag for protocol violations.

## Operation
- Line index is `pmem_address[LINE_ADDR_BITS+3:4]`. Address bits above that field alias, meaning the array wraps.
- States:
  - IDLE: if `pmem_read` or `pmem_write` is high, latch the op, the index and (for writes) `pmem_wdata`. Load `cnt = LATENCY-1`, then go to BUSY. Otherwise stay in IDLE.
  - BUSY:
    - If the latched request signal has dropped, abort: go to IDLE, no array write, no resp.
    - Else if `cnt != 0`, decrement `cnt`.
    - Else (`cnt == 0`), go to RESP.
  - RESP: assert `pmem_resp`. For a read, drive `pmem_rdata` from the latched index. For a write, commit the latched line to the array on this edge. Then go to DONE.
  - DONE: one turnaround cycle. Requests are ignored. Go to IDLE.
- Read and write both high in IDLE: the write wins and `pmem_error` is set.
- Address or op change while BUSY: ignored, because the latched values are used. `pmem_error` is set.
- Reset (`reset_n` low at an edge):
  - Forces IDLE, `cnt = 0`, `pmem_resp = 0`, `pmem_rdata = 0`, `pmem_error = 0`.
  - Array contents are not reset.
  - An in-flight write is dropped.
- Write-then-read to the same line returns the new data. The write commits in RESP, before any later request can be accepted.

## Timing
- Request first seen high in cycle 0 (state IDLE) → `pmem_resp` is high in cycle LATENCY+1.
  - With LATENCY=1, resp is in cycle 2.
- `pmem_resp` is high for exactly one cycle.
- The requester must drop its request in the cycle after resp. DONE guarantees no re-acceptance even if it drops late by one cycle.
- Earliest back-to-back acceptance is cycle LATENCY+3, so throughput is one line per LATENCY+3 cycles.
- `pmem_rdata` is registered. It is updated on the edge entering RESP and stable through RESP and after.
- Counter width is 8 bits with no wrap. LATENCY is checked at elaboration: an assertion fires if it is outside 1..255.
- All outputs are registered, with no combinational input-to-output paths.

## Structure
- Add the following to `lc3b_types`:
  - typedef `lc3b_pmem_state` as enum `{PMEM_IDLE, PMEM_BUSY, PMEM_RESP, PMEM_DONE}`
  - typedef `lc3b_pmem_cnt` as `logic [7:0]`
- Reuse `lc3b_word` and `lc3b_l2_line`.
- One sub-module: `pmem_line_array`. It is a 2^LINE_ADDR_BITS × 128 array with a synchronous write port and a synchronous read port, and no reset.
- The FSM, counter and request latches live in `pmem_responder`.

## Test plan
- **Reset:** hold `reset_n=0` for 3 cycles with `pmem_read=1` → resp, rdata and error stay 0. After release, the read is accepted and resp arrives LATENCY+1 cycles later.
- **Write then read:** with LATENCY=4, write 128'hDEADBEEF_0123_4567_89AB_CDEF_0011_2233 to 16'h0120 → resp in cycle 5. Then read 16'h012E → rdata equals that line, with resp in cycle 5 relative to the read.
- **Aliasing:** with LINE_ADDR_BITS=8, write line A to 16'h0010, then read 16'h1010 → returns A.
- **Abort:** drop `pmem_write` in cycle 2 of a LATENCY=4 write to 16'h0200 with data B → no resp. A subsequent read of 16'h0200 returns the prior contents, not B.
- **Conflict:** raise read and write together with data C at 16'h0300 → the write is performed, resp pulses once, and `pmem_error=1` until reset.
- **Back-to-back:** issue reads with the requester dropping 1 cycle late → exactly one resp per request, with accept intervals of LATENCY+3 cycles.
